// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the pipeline.
//   - Selects the GPR write data, either the ALU/address result or a load word
//     extracted from the data-memory read word with sign or zero extension.
//   - Holds the HI/LO registers, a sticky flag for illegal load byte enables,
//     and a counter of committed write-backs.
//   - Optional macro WB_HILO_BYPASS_EN: when defined, hi_o/lo_o forward the
//     incoming HI/LO pair while wb_whilo=1. When undefined, hi_o/lo_o come
//     from the registers only.
`timescale 1ns/1ps
module wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_dreg,
   input  logic [4:0]  wb_wa,
   input  logic        wb_wreg,
   input  logic        wb_mreg,
   input  logic [3:0]  wb_dre,
   input  logic        wb_lu,
   input  logic [31:0] dm_rdata,
   input  logic        wb_whilo,
   input  logic [63:0] wb_hilo,
   output logic [4:0]  rf_wa,
   output logic        rf_wreg,
   output logic [31:0] rf_wd,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        align_err,
   output logic [31:0] commit_cnt
);

   // Byte lanes of the memory word; lane 3 is bits 31:24.
   logic [7:0] lane [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = dm_rdata[8*gi +: 8];
      end
   endgenerate

   logic [31:0] load_data;
   logic        dre_legal;
   logic        dre_illegal;

   // Load extraction: right-justify the selected field, then extend it.
   always_comb begin
      load_data = 32'h0;
      dre_legal = 1'b1;
      case (wb_dre)
         4'b1111: load_data = dm_rdata;
         4'b1100: load_data = wb_lu ? {16'h0, dm_rdata[31:16]}
                                    : {{16{dm_rdata[31]}}, dm_rdata[31:16]};
         4'b0011: load_data = wb_lu ? {16'h0, dm_rdata[15:0]}
                                    : {{16{dm_rdata[15]}}, dm_rdata[15:0]};
         4'b1000: load_data = wb_lu ? {24'h0, lane[3]} : {{24{lane[3][7]}}, lane[3]};
         4'b0100: load_data = wb_lu ? {24'h0, lane[2]} : {{24{lane[2][7]}}, lane[2]};
         4'b0010: load_data = wb_lu ? {24'h0, lane[1]} : {{24{lane[1][7]}}, lane[1]};
         4'b0001: load_data = wb_lu ? {24'h0, lane[0]} : {{24{lane[0][7]}}, lane[0]};
         default: dre_legal = 1'b0;
      endcase
   end

   // Byte enables only matter for loads; ALU results ignore them.
   assign dre_illegal = wb_mreg & ~dre_legal;

   // GPR write port; purely combinational and deliberately not gated by rst.
   always_comb begin
      rf_wa   = wb_wa;
      rf_wreg = wb_wreg & (wb_wa != 5'd0) & ~dre_illegal;
      if (!wb_mreg)
         rf_wd = wb_dreg;
      else if (dre_illegal)
         rf_wd = 32'h0;
      else
         rf_wd = load_data;
   end

   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        err_q, err_d;
   logic [31:0] cnt_q, cnt_d;

   // Next-state for HI/LO, the sticky error flag and the commit counter.
   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      err_d = err_q;
      cnt_d = cnt_q;
      if (wb_whilo) begin
         hi_d = wb_hilo[63:32];
         lo_d = wb_hilo[31:0];
      end
      if (dre_illegal && wb_wreg)
         err_d = 1'b1;
      // A GPR write and a HI/LO write in the same cycle commit once.
      if (rf_wreg || wb_whilo)
         cnt_d = cnt_q + 32'd1;
   end

   // State registers; reset wins over any simultaneous write or increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q  <= 32'h0;
         lo_q  <= 32'h0;
         err_q <= 1'b0;
         cnt_q <= 32'h0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

`ifdef WB_HILO_BYPASS_EN
   // Forward the HI/LO pair being written so the execute stage sees it at once.
   always_comb begin
      hi_o = wb_whilo ? wb_hilo[63:32] : hi_q;
      lo_o = wb_whilo ? wb_hilo[31:0]  : lo_q;
   end
`else
   // Registered HI/LO only; a write shows up the cycle after wb_whilo.
   always_comb begin
      hi_o = hi_q;
      lo_o = lo_q;
   end
`endif

   assign align_err  = err_q;
   assign commit_cnt = cnt_q;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit; the single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-003 SHALL have port wb_dreg, input, 32 bits; ALU/address result from MEM/WB register.
REQ-004 SHALL have port wb_wa, input, 5 bits; GPR write-back address.
REQ-005 SHALL have port wb_wreg, input, 1 bit; GPR write request.
REQ-006 SHALL have port wb_mreg, input, 1 bit; 1 = write-back data comes from data memory.
REQ-007 SHALL have port wb_dre, input, 4 bits; load byte enables, bit3 = bits 31:24 (big-endian lanes).
REQ-008 SHALL have port wb_lu, input, 1 bit; 1 = zero-extend sub-word load, 0 = sign-extend.
REQ-009 SHALL have port dm_rdata, input, 32 bits; data-memory read word for the instruction in WB.
REQ-010 SHALL have ports wb_whilo (input, 1 bit) and wb_hilo (input, 64 bits; [63:32]=HI, [31:0]=LO).
REQ-011 SHALL have ports rf_wa (output, 5), rf_wreg (output, 1) and rf_wd (output, 32); GPR write port.
REQ-012 SHALL have ports hi_o and lo_o (output, 32 each); current HI/LO for the execute stage.
REQ-013 SHALL have ports align_err (output, 1; sticky illegal-dre flag) and commit_cnt (output, 32; write-back counter).

Function
REQ-014 SHALL drive rf_wa = wb_wa combinationally, zero latency.
REQ-015 SHALL drive rf_wd = wb_dreg when wb_mreg=0, ignoring wb_dre.
REQ-016 SHALL, when wb_mreg=1, extract from dm_rdata: dre 1111 -> whole word; 1100 -> bits 31:16; 0011 -> bits 15:0; 1000/0100/0010/0001 -> matching single byte.
REQ-017 SHALL right-justify sub-word data in rf_wd and fill upper bits with the field MSB when wb_lu=0, zeros when wb_lu=1.
REQ-018 SHALL treat any other dre value with wb_mreg=1 as illegal: rf_wd = 0, rf_wreg = 0.
REQ-019 SHALL drive rf_wreg = wb_wreg AND (wb_wa != 0) AND NOT illegal-dre.
REQ-020 SHALL hold HI and LO registers, loaded from wb_hilo[63:32] and wb_hilo[31:0] on a clock edge with wb_whilo=1, otherwise unchanged.
REQ-021 SHALL set align_err on the edge following an illegal-dre cycle where wb_wreg=1; it stays set until reset.
REQ-022 SHALL increment commit_cnt by exactly 1 on each edge where rf_wreg=1 or wb_whilo=1 (both together count once), wrapping 0xFFFFFFFF -> 0.
REQ-023 SHALL ignore wb_dre, dm_rdata and wb_lu for counting and HI/LO purposes.

Reset
REQ-024 SHALL, on an edge with rst=1, clear HI, LO, align_err and commit_cnt to 0, taking precedence over any simultaneous write or increment.
REQ-025 SHALL keep rf_* outputs purely combinational from inputs during reset; rf_wreg is not gated by rst.

Configuration
REQ-026 SHALL support macro WB_HILO_BYPASS_EN; when defined, hi_o/lo_o equal wb_hilo halves while wb_whilo=1, else the registers.
REQ-027 SHALL, without WB_HILO_BYPASS_EN, drive hi_o/lo_o from the registers only; a write becomes visible the cycle after wb_whilo.

Verification
REQ-028 SHALL verify: mreg=1, dre=0010, lu=0, dm_rdata=0x1234_80FF -> rf_wd=0xFFFF_FF80; lu=1 -> 0x0000_0080.
REQ-029 SHALL verify: wreg=1, wa=0, mreg=0, dreg=0xDEAD_BEEF -> rf_wreg=0, commit_cnt unchanged.
REQ-030 SHALL verify: whilo=1, hilo=0x0000_0001_FFFF_FFFE -> with bypass hi_o=1, lo_o=0xFFFF_FFFE same cycle; without, next cycle.
REQ-031 SHALL verify: mreg=1, wreg=1, dre=0110 -> rf_wreg=0, rf_wd=0, align_err=1 next cycle and held until rst=1.
REQ-032 SHALL verify: commit_cnt forced to 0xFFFF_FFFF via writes, then wreg=1 and whilo=1 same cycle -> commit_cnt=0.
REQ-033 SHALL verify: rst=1 concurrent with whilo=1 -> HI=LO=0, commit_cnt=0 after the edge.
